// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer/deserializer pair.
package serdes_pkg;
    localparam bit LSW_FIRST = 1'b1;
    localparam bit MSW_FIRST = 1'b0;

    // Number of narrow words needed to carry 'total' bits at 'width' bits each.
    function automatic int words_for(int width, int total);
        return (total + width - 1) / width;
    endfunction
endpackage

// File: rtl/serializer_if.sv
// Wide-word input and narrow-word output streams of the serializer.
interface serializer_if #(
    parameter int WIDTH     = 8,
    parameter int NUM_WORDS = 4
);
    logic [NUM_WORDS*WIDTH-1:0] i_data;
    logic                       i_dv;
    logic                       o_ready;
    logic [WIDTH-1:0]           o_data;
    logic                       o_dv;
    logic                       o_last;
    logic                       i_ready;

    modport slave  (input  i_data, i_dv, i_ready, output o_ready, o_data, o_dv, o_last);
    modport master (output i_data, i_dv, i_ready, input  o_ready, o_data, o_dv, o_last);
endinterface

// File: rtl/serializer.sv
// Wide-to-narrow stream converter with a one-entry holding buffer so that
// consecutive wide words stream out without idle cycles.
module serializer
    import serdes_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int NUM_WORDS     = 4,
    parameter bit LITTLE_ENDIAN = LSW_FIRST
) (
    input logic        clk,
    input logic        i_reset,
    serializer_if.slave bus
);
    localparam int TW = NUM_WORDS * WIDTH;
    localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

    if (NUM_WORDS < 2) begin : g_bad_num_words
        $error("serializer: NUM_WORDS must be >= 2");
    end

    logic [TW-1:0] sh;
    logic [TW-1:0] hold;
    logic [CW-1:0] cnt;
    logic          active;
    logic          hold_v;

    logic acc, xfer, lastx, sh_free;

    assign acc     = bus.i_dv && !hold_v;
    assign xfer    = active && bus.i_ready;
    assign lastx   = xfer && (cnt == LAST);
    assign sh_free = lastx || !active;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            sh     <= '0;
            hold   <= '0;
            cnt    <= '0;
            active <= 1'b0;
            hold_v <= 1'b0;
        end else if (xfer && !lastx) begin
            sh  <= LITTLE_ENDIAN ? (sh >> WIDTH) : (sh << WIDTH);
            cnt <= cnt + 1'b1;
            if (acc) begin
                hold   <= bus.i_data;
                hold_v <= 1'b1;
            end
        end else if (sh_free) begin
            cnt <= '0;
            if (hold_v) begin
                // o_ready is low here, so no new word can arrive this cycle
                sh     <= hold;
                hold_v <= 1'b0;
                active <= 1'b1;
            end else if (acc) begin
                sh     <= bus.i_data;
                active <= 1'b1;
            end else begin
                active <= 1'b0;
            end
        end else if (acc) begin
            hold   <= bus.i_data;
            hold_v <= 1'b1;
        end
    end

    assign bus.o_ready = !hold_v;
    assign bus.o_dv    = active;
    assign bus.o_last  = active && (cnt == LAST);
    assign bus.o_data  = LITTLE_ENDIAN ? sh[WIDTH-1:0] : sh[TW-1 -: WIDTH];
endmodule

// File: doc/serializer.md
# serializer

Wide-to-narrow converter, the transmit-side counterpart of the team's deserializer. It accepts one NUM_WORDS*WIDTH-bit word and emits it as NUM_WORDS consecutive WIDTH-bit words over a valid/ready stream. Word order is selectable by parameter. A one-entry holding buffer lets the next wide word be accepted while the current one is still shifting out, so a stream can run with no idle cycles between wide words.

## Interface
- WIDTH, 8, narrow output word width in bits
- NUM_WORDS, 4, narrow words per wide word; must be ≥ 2 (elaboration error otherwise)
- LITTLE_ENDIAN, 1, 1 = emit least-significant word first; 0 = emit most-significant word first
- clk  input  1  clock; all state updates on its rising edge
- i_reset  input  1  reset, synchronous, active-high
- i_data  input  NUM_WORDS*WIDTH  wide word to serialize
- i_dv  input  1  i_data valid; the word is accepted in a cycle where i_dv && o_ready
- o_ready  output  1  can accept a wide word; equals !hold_v
- o_data  output  WIDTH  current narrow word
- o_dv  output  1  o_data valid
- o_last  output  1  o_data is the final narrow word of its wide word
- i_ready  input  1  downstream accepts; a narrow word transfers in a cycle where o_dv && i_ready

## Operation
- State registers:
  - shifter sh[NUM_WORDS*WIDTH], with valid flag active
  - narrow-word counter cnt, $clog2(NUM_WORDS) bits
  - holding register hold[NUM_WORDS*WIDTH], with valid flag hold_v
- Per-cycle terms:
  - acc = i_dv && o_ready
  - xfer = active && i_ready
  - lastx = xfer && cnt == NUM_WORDS-1
  - Shifter becomes free when lastx is true or when active is 0.
- Output mapping:
  - o_data: sh[WIDTH-1:0] if LE, else sh[top WIDTH bits]
  - o_dv = active
  - o_last = active && cnt == NUM_WORDS-1
- Cases:
  - xfer and not last: shift sh by WIDTH (right if LE, left if BE, zero fill), cnt+1. If acc, load hold and set hold_v.
  - Shifter free and hold_v: load sh from hold, clear hold_v, cnt=0, active=1. acc is impossible in this case, because o_ready=0.
  - Shifter free, !hold_v, and acc: load sh directly from i_data, cnt=0, active=1. The word bypasses hold.
  - Shifter free, !hold_v, and !acc: active=0, cnt=0.
  - Shifter busy, no xfer, and acc: load hold and set hold_v; sh does not change.
- Backpressure: while o_dv && !i_ready, o_data, o_dv and o_last hold steady.
- i_dv with o_ready=0 is ignored, not queued. The upstream must hold i_data and i_dv until it sees o_ready.
- i_reset overrides every other condition. Partially sent words are discarded; no truncated o_last is emitted.

## Timing
- Reset values: o_dv=0, o_last=0, o_data=0, o_ready=1. Internally cnt=0, active=0, hold_v=0, sh=0, hold=0.
- Latency: a word accepted into an empty block in cycle N gives o_dv=1 with the first narrow word in cycle N+1.
- Throughput with i_ready held at 1: one wide word per NUM_WORDS cycles, with no bubble between words. The next word's first narrow word appears in the cycle right after o_last.
- o_ready falls the cycle after hold is filled. It rises the cycle after lastx moves hold into sh.
- o_ready, o_dv and o_last come directly from registers, with no combinational path from i_dv or i_ready. o_data is a static slice of sh.

## Structure
- Shared package serdes_pkg:
  - localparam bit LSW_FIRST=1, MSW_FIRST=0, used for LITTLE_ENDIAN in both serializer and deserializer
  - function words_for(width, total) for integrators
- Single flat module. The holding register is a one-entry buffer coded inline; no sub-module.

## Test plan
All scenarios use WIDTH=8, NUM_WORDS=4.
- LE, i_ready=1, one word 0x44332211 → o_data 0x11, 0x22, 0x33, 0x44 on four consecutive cycles; o_last only on 0x44; o_dv=0 afterwards.
- BE, same stimulus → 0x44, 0x33, 0x22, 0x11; o_last on 0x11.
- Back-to-back: 0xDDCCBBAA then 0x88776655 with i_dv held → 8 contiguous o_dv cycles: AA BB CC DD 55 66 77 88. o_ready=0 from the cycle after the second accept until the cycle after DD's transfer.
- Backpressure: i_ready=0 for 3 cycles while 0x22 is shown → 0x22 and o_dv held steady; sequence then resumes with 0x33 and 0x44.
- Reset mid-stream: assert i_reset after 0x22 transfers, with hold full → next cycle o_dv=0, o_ready=1. A later word 0x0A0B0C0D emits 0D 0C 0B 0A with no stale data.
- Loopback into the deserializer with matching parameters: 100 random wide words with random i_ready → each o_dv pulse on the deserializer carries exactly the original word, in order.
